// File: rtl/alu_pipe_ctrl.sv
// alu_pipe_ctrl: execution unit with a valid/ready handshake on both sides.
// Single-cycle ops (add, and, sub, srl, sll, illegal) complete one cycle after
// accept; multiply and the fused ops complete MUL_LAT cycles after accept. One
// operation is in flight at a time, and the result is held under backpressure.
//
// Ports:
//   clk        clock
//   reset_n    synchronous, active-low reset
//   in_valid   operation request valid
//   in_ready   unit can accept an operation this cycle
//   op         4-bit opcode
//   a, b       WIDTH-bit operands
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     WIDTH-bit result, 0 whenever out_valid is low
//   zero       result == 0, qualified by out_valid
//   illegal    completed op was unsupported, qualified by out_valid
module alu_pipe_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int unsigned CntW = $clog2(MUL_LAT);
   localparam int unsigned PW   = 2 * WIDTH;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ill_q, ill_d;

   logic             accept;
   logic             op_multi;
   logic [WIDTH-1:0] sc_res;
   logic             sc_ill;
   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    prod;
   logic [PW-1:0]    mc_full;

   // Multi-cycle class: mul and the fused ops built around a*b.
   always_comb begin
      op_multi = 1'b0;
      case (op)
         4'b0100, 4'b1001, 4'b1010, 4'b1011, 4'b1100: op_multi = 1'b1;
         default:                                     op_multi = 1'b0;
      endcase
   end

   // Single-cycle results come straight from the inputs at accept.
   always_comb begin
      sc_res = '0;
      sc_ill = 1'b0;
      case (op)
         4'b0001: sc_res = a + b;
         4'b0010: sc_res = a & b;
         4'b0011: sc_res = a - b;
         4'b0111: sc_res = a >> 1;
         4'b1000: sc_res = a << 1;
         default: sc_ill = 1'b1;
      endcase
   end

   // Multi-cycle results use the registered operands at full product width;
   // only the final value is truncated to WIDTH.
   always_comb begin
      a_ext   = PW'(a_q);
      prod    = a_ext * PW'(b_q);
      mc_full = '0;
      case (op_q)
         4'b0100: mc_full = prod;
         4'b1001: mc_full = prod - a_ext;
         4'b1010: mc_full = (prod << 2) - a_ext;
         4'b1011: mc_full = prod + a_ext;
         4'b1100: mc_full = (a_ext << 1) + a_ext;
         default: mc_full = '0;
      endcase
   end

   // A DONE result being consumed frees the unit in the same cycle, which is
   // what allows back-to-back single-cycle ops at one per cycle.
   assign in_ready = reset_n && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      ill_d   = ill_q;
      case (state_q)
         StIdle, StDone: begin
            if ((state_q == StDone) && out_ready) begin
               state_d = StIdle;
            end
            if (accept) begin
               op_d = op;
               a_d  = a;
               b_d  = b;
               if (op_multi) begin
                  cnt_d   = CntW'(MUL_LAT - 1);
                  state_d = StBusy;
               end else begin
                  res_d   = sc_res;
                  ill_d   = sc_ill;
                  state_d = StDone;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               res_d   = mc_full[WIDTH-1:0];
               ill_d   = 1'b0;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid = (state_q == StDone);
   assign result    = out_valid ? res_q : '0;
   assign zero      = out_valid && (res_q == '0);
   assign illegal   = out_valid && ill_q;

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Directed bench for alu_pipe_ctrl: an 8-bit/MUL_LAT=3 instance and a
// 16-bit/MUL_LAT=5 instance share clock and reset.
module tb_alu_pipe_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
   logic [3:0] op8 = 4'h0;
   logic [7:0] a8 = '0, b8 = '0, result8;
   logic       zero8, illegal8;

   logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
   logic [3:0]  op16 = 4'h0;
   logic [15:0] a16 = '0, b16 = '0, result16;
   logic        zero16, illegal16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_pipe_ctrl #(.WIDTH(8), .MUL_LAT(3)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .zero(zero8), .illegal(illegal8)
   );

   alu_pipe_ctrl #(.WIDTH(16), .MUL_LAT(5)) dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
      .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
      .zero(zero16), .illegal(illegal16)
   );

   always @(posedge clk) begin
      if (reset_n && in_valid8) assert (!$isunknown(op8)) else $error("X on op8");
      if (reset_n && in_valid16) assert (!$isunknown(op16)) else $error("X on op16");
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   // Issue one op on dut8 and wait (bounded) for its result. lat counts cycles
   // from the accept cycle to the first out_valid cycle; busy counts the cycles
   // in between with in_ready low.
   task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int busy, output logic [7:0] r,
                         output logic z, output logic il);
      int guard;
      @(negedge clk);
      op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b1;
      #1;
      guard = 0;
      while (!in_ready8 && guard < 20) begin @(negedge clk); #1; guard++; end
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      lat = 1; busy = 0;
      while (!out_valid8 && lat < 20) begin
         if (!in_ready8) busy++;
         @(negedge clk); #1; lat++;
      end
      r = result8; z = zero8; il = illegal8;
   endtask

   task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output int busy, output logic [15:0] r);
      int guard;
      @(negedge clk);
      op16 = o; a16 = x; b16 = y; in_valid16 = 1'b1; out_ready16 = 1'b1;
      #1;
      guard = 0;
      while (!in_ready16 && guard < 20) begin @(negedge clk); #1; guard++; end
      @(negedge clk);
      in_valid16 = 1'b0;
      #1;
      lat = 1; busy = 0;
      while (!out_valid16 && lat < 20) begin
         if (!in_ready16) busy++;
         @(negedge clk); #1; lat++;
      end
      r = result16;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (in_ready8 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready8); end
      n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
      n_cmp++; if (result8 !== 8'h00) begin n_bad++; $display("FAIL reset_result got %h want 00", result8); end
      n_cmp++; if (zero8 !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", zero8); end
      n_cmp++; if (illegal8 !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal8); end
      n_cmp++; if (out_valid16 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid16 got %b want 0", out_valid16); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready8); end
      n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_valid got %b want 0", out_valid8); end
   endtask

   task automatic test_add();
      int lat, busy; logic [7:0] r; logic z, il;
      issue8(4'b0001, 8'hF0, 8'h20, lat, busy, r, z, il);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency got %0d want 1", lat); end
      n_cmp++; if (r !== 8'h10) begin n_bad++; $display("FAIL add_result got %h want 10", r); end
      n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b want 0", z); end
      n_cmp++; if (il !== 1'b0) begin n_bad++; $display("FAIL add_illegal got %b want 0", il); end
   endtask

   task automatic test_single_ops();
      logic [3:0] ops [8];
      logic [7:0] xa [8], xb [8], ex [8];
      logic       exi [8];
      int lat, busy; logic [7:0] r; logic z, il;
      ops = '{4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b0000, 4'b0101, 4'b1101, 4'b1111};
      xa  = '{8'hF0, 8'h01, 8'h81, 8'h81, 8'h12, 8'h34, 8'h56, 8'hFF};
      xb  = '{8'h3C, 8'h02, 8'h00, 8'h00, 8'h34, 8'h56, 8'h78, 8'hFF};
      ex  = '{8'h30, 8'hFF, 8'h40, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
      exi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         issue8(ops[i], xa[i], xb[i], lat, busy, r, z, il);
         n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_latency op=%b got %0d want 1", ops[i], lat); end
         n_cmp++; if (r !== ex[i]) begin n_bad++; $display("FAIL single_result op=%b got %h want %h", ops[i], r, ex[i]); end
         n_cmp++; if (il !== exi[i]) begin n_bad++; $display("FAIL single_illegal op=%b got %b want %b", ops[i], il, exi[i]); end
      end
   endtask

   task automatic test_mul();
      int lat, busy; logic [7:0] r; logic z, il;
      issue8(4'b0100, 8'h0F, 8'h11, lat, busy, r, z, il);
      n_cmp++; if (busy !== 2) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 2", busy); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mul_latency got %0d want 3", lat); end
      n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL mul_result got %h want ff", r); end
      n_cmp++; if (il !== 1'b0) begin n_bad++; $display("FAIL mul_illegal got %b want 0", il); end
   endtask

   task automatic test_special();
      logic [3:0] ops [5];
      logic [7:0] xa [5], xb [5], ex [5];
      logic       exz [5];
      int lat, busy; logic [7:0] r; logic z, il;
      ops = '{4'b1010, 4'b1001, 4'b1011, 4'b1100, 4'b1001};
      xa  = '{8'h03, 8'h00, 8'h03, 8'h60, 8'h03};
      xb  = '{8'h05, 8'h07, 8'h05, 8'h00, 8'h02};
      ex  = '{8'h39, 8'h00, 8'h12, 8'h20, 8'h03};
      exz = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         issue8(ops[i], xa[i], xb[i], lat, busy, r, z, il);
         n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL special_latency op=%b got %0d want 3", ops[i], lat); end
         n_cmp++; if (r !== ex[i]) begin n_bad++; $display("FAIL special_result op=%b got %h want %h", ops[i], r, ex[i]); end
         n_cmp++; if (z !== exz[i]) begin n_bad++; $display("FAIL special_zero op=%b got %b want %b", ops[i], z, exz[i]); end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      op8 = 4'b0011; a8 = 8'h01; b8 = 8'h02; in_valid8 = 1'b1; out_ready8 = 1'b0;
      #1;
      n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL bp_initial_ready got %b want 1", in_ready8); end
      @(negedge clk);
      // Next op waits on the inputs; the held sub must not see these operands.
      op8 = 4'b0001; a8 = 8'h05; b8 = 8'h06;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         n_cmp++; if (out_valid8 !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", k, out_valid8); end
         n_cmp++; if (result8 !== 8'hFF) begin n_bad++; $display("FAIL bp_hold_result cyc=%0d got %h want ff", k, result8); end
         n_cmp++; if (in_ready8 !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready cyc=%0d got %b want 0", k, in_ready8); end
      end
      @(negedge clk);
      out_ready8 = 1'b1;
      #1;
      n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", in_ready8); end
      n_cmp++; if (result8 !== 8'hFF) begin n_bad++; $display("FAIL bp_release_result got %h want ff", result8); end
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      n_cmp++; if (out_valid8 !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid got %b want 1", out_valid8); end
      n_cmp++; if (result8 !== 8'h0B) begin n_bad++; $display("FAIL bp_next_result got %h want 0b", result8); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [5];
      logic [7:0] xa [5], xb [5], ex [5];
      logic       exi [5];
      ops = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0110};
      xa  = '{8'h01, 8'h10, 8'hFF, 8'h7F, 8'h55};
      xb  = '{8'h01, 8'h20, 8'h01, 8'h7F, 8'hAA};
      ex  = '{8'h02, 8'h30, 8'h00, 8'hFE, 8'h00};
      exi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_cmp++; if (out_valid8 !== 1'b1) begin n_bad++; $display("FAIL b2b_valid idx=%0d got %b want 1", i - 1, out_valid8); end
            n_cmp++; if (result8 !== ex[i-1]) begin n_bad++; $display("FAIL b2b_result idx=%0d got %h want %h", i - 1, result8, ex[i-1]); end
            n_cmp++; if (illegal8 !== exi[i-1]) begin n_bad++; $display("FAIL b2b_illegal idx=%0d got %b want %b", i - 1, illegal8, exi[i-1]); end
         end
         if (i < 5) begin
            op8 = ops[i]; a8 = xa[i]; b8 = xb[i]; in_valid8 = 1'b1; out_ready8 = 1'b1;
            #1;
            n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready idx=%0d got %b want 1", i, in_ready8); end
         end else begin
            in_valid8 = 1'b0;
         end
      end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      op8 = 4'b0100; a8 = 8'h03; b8 = 8'h03; in_valid8 = 1'b1; out_ready8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      n_cmp++; if (in_ready8 !== 1'b0) begin n_bad++; $display("FAIL rb_busy_ready got %b want 0", in_ready8); end
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL rb_valid got %b want 0", out_valid8); end
      n_cmp++; if (result8 !== 8'h00) begin n_bad++; $display("FAIL rb_result got %h want 00", result8); end
      n_cmp++; if (in_ready8 !== 1'b0) begin n_bad++; $display("FAIL rb_ready_in_reset got %b want 0", in_ready8); end
      reset_n = 1'b1;
      #1;
      n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL rb_ready_release got %b want 1", in_ready8); end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         n_cmp++; if ({out_valid8, result8} !== 9'h000) begin n_bad++; $display("FAIL rb_stale cyc=%0d got valid=%b result=%h want 0/00", k, out_valid8, result8); end
      end
   endtask

   task automatic test_wide();
      int lat, busy; logic [15:0] r;
      issue16(4'b0100, 16'h00FF, 16'h0101, lat, busy, r);
      n_cmp++; if (busy !== 4) begin n_bad++; $display("FAIL w_mul_busy got %0d want 4", busy); end
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL w_mul_latency got %0d want 5", lat); end
      n_cmp++; if (r !== 16'hFFFF) begin n_bad++; $display("FAIL w_mul_result got %h want ffff", r); end
      issue16(4'b0011, 16'h0001, 16'h0002, lat, busy, r);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w_sub_latency got %0d want 1", lat); end
      n_cmp++; if (r !== 16'hFFFF) begin n_bad++; $display("FAIL w_sub_result got %h want ffff", r); end
      issue16(4'b1010, 16'h1000, 16'h0010, lat, busy, r);
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL w_fused_latency got %0d want 5", lat); end
      n_cmp++; if (r !== 16'hF000) begin n_bad++; $display("FAIL w_fused_result got %h want f000", r); end
      issue16(4'b0001, 16'hFFFF, 16'h0002, lat, busy, r);
      n_cmp++; if (r !== 16'h0001) begin n_bad++; $display("FAIL w_add_wrap got %h want 0001", r); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_single_ops();
      test_mul();
      test_special();
      test_backpressure();
      test_back_to_back();
      test_reset_busy();
      test_wide();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_pipe_ctrl.md
Name: alu_pipe_ctrl

Overview:
- Parametrised next-generation execution unit for the multiprocessor datapath. Replaces the fixed 8-bit, start/done ALU.
- Performs single-cycle arithmetic and logic ops, multi-cycle multiply, and the special fused ops behind a valid/ready handshake.
- Accepts at most one operation in flight. Holds the result under downstream backpressure.
- Sits between the instruction issue stage and the register-file writeback.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 4..32.
- MUL_LAT, 3: cycles from accept to out_valid for multiply and special ops; legal range 2..8.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept an operation this cycle
- op  in  4  opcode
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0; valid only while out_valid is high
- illegal  out  1  the completed op was an unsupported opcode; valid only while out_valid is high

Behaviour:
- Reset:
  - reset_n is sampled on the clk edge, synchronous, active-low.
  - Outputs: in_ready=0 during reset, 1 the first cycle after reset; out_valid=0, result=0, zero=0, illegal=0.
  - FSM goes to IDLE; latency counter=0.
  - Reset asserted mid-operation aborts the op. No out_valid is produced for it.
- Accept:
  - An operation is accepted on a clk edge with in_valid && in_ready.
  - op, a and b are registered at accept. Later input changes have no effect.
- Opcodes, all arithmetic modulo 2^WIDTH (result = low WIDTH bits):
  - 0001 add a+b
  - 0010 and a&b
  - 0011 sub a-b (wraps)
  - 0111 srl a>>1, zero fill
  - 1000 sll a<<1
  - 0100 mul a*b
  - 1001 a*b-a
  - 1010 4*a*b-a
  - 1011 a*b+a
  - 1100 3*a
  - All others (0000, 0101, 0110, 1101-1111): result=0, illegal=1, single-cycle latency.
- Latency:
  - Single-cycle class (add, and, sub, srl, sll, illegal): out_valid rises on the edge after the accept edge.
  - Multi-cycle class (mul, 1001-1100): out_valid rises MUL_LAT edges after the accept edge.
  - The internal product is 2*WIDTH bits wide; truncation to WIDTH happens only at the final result.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept of a single-cycle op, go to DONE. On accept of a multi-cycle op, load counter=MUL_LAT-1 and go to BUSY.
  - BUSY: in_ready=0. Counter decrements each cycle. When counter==1, the next edge goes to DONE with result registered.
  - DONE: out_valid=1; result, zero and illegal are stable.
    - If out_ready=0, remain in DONE and hold all outputs.
    - If out_ready=1, the result is consumed on this edge and in_ready=1 in the same cycle (combinational from out_ready).
    - Simultaneous in_valid: accept the new op in the same edge and go to DONE or BUSY per its class. This gives back-to-back single-cycle ops at one per cycle.
    - If out_ready=1 and in_valid=0, go to IDLE.
- Output rules:
  - out_valid must not drop without a handshake.
  - result is 0 whenever out_valid=0.
- Concurrency and assertions:
  - No operation is ever accepted while BUSY.
  - in_valid held high while in_ready=0 is legal and is not lost.
  - X on op with in_valid=1 is a bench assertion failure.

Test Plan:
- Reset then add a=8'hF0, b=8'h20 (WIDTH=8) -> out_valid 1 cycle after accept, result=8'h10, zero=0, illegal=0.
- mul a=8'h0F, b=8'h11, MUL_LAT=3, out_ready=1 -> in_ready=0 for 2 cycles, out_valid 3 cycles after accept, result=8'hFF.
- Special 1010 a=3, b=5 -> result=8'h39 (60-3). Op 1001 a=0, b=7 -> result=0, zero=1.
- sub a=1, b=2 held under out_ready=0 for 5 cycles -> out_valid and result=8'hFF stable throughout, in_ready=0. Raise out_ready -> completes; a new add is accepted the same edge.
- Stream of 4 back-to-back adds with in_valid=out_ready=1 -> one result per cycle, in order. op=0110 -> result=0, illegal=1.
- Assert reset_n=0 during BUSY of a mul -> next cycle out_valid=0, result=0, in_ready=1 after release. No stale result ever appears.
- Rerun the mul and sub scenarios with WIDTH=16, MUL_LAT=5 -> 16'h00FF*16'h0101=16'hFFFF at 5 cycles, wrap behaviour matches.
